// File: rtl/bitonic_pkg.sv
// Shared definitions for the final bitonic merge stage: default width,
// lane count, FSM state encoding and the lane pairs used by each layer.
package bitonic_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int LANES     = 8;
  localparam int CAS_UNITS = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMP4 = 3'd1,
    CMP2 = 3'd2,
    CMP1 = 3'd3,
    DONE = 3'd4
  } state_e;

  // Zero-based lane pairs per layer: unit k compares lane *_A[k] (gets min)
  // with lane *_B[k] (gets max).
  localparam int CMP4_A [CAS_UNITS] = '{0, 1, 2, 3};
  localparam int CMP4_B [CAS_UNITS] = '{4, 5, 6, 7};
  localparam int CMP2_A [CAS_UNITS] = '{0, 1, 4, 5};
  localparam int CMP2_B [CAS_UNITS] = '{2, 3, 6, 7};
  localparam int CMP1_A [CAS_UNITS] = '{0, 2, 4, 6};
  localparam int CMP1_B [CAS_UNITS] = '{1, 3, 5, 7};

endpackage

// File: rtl/bitonic_cas.sv
// Combinational compare-exchange unit: lo = min(a,b), hi = max(a,b).
// Equal operands pass through unswapped; compare is unsigned.
module bitonic_cas #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap;

  // Swap only when b is strictly smaller, so ties keep their lane.
  always_comb begin
    swap = (b < a);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/bitonic_s3_merge.sv
// Final merge stage of the 8-lane bitonic sorter. Four shared
// compare-exchange units are time-multiplexed over three layers
// (CMP4 -> CMP2 -> CMP1) by a small FSM.
// Optional feature macro: BITONIC_S3_CHECK_EN adds the bitonic_err port
// and the input-shape check.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE (and not in reset); out_valid is
// high only in DONE and the result is held stable until out_ready is seen.
module bitonic_s3_merge
  import bitonic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number_in1,
  input  logic [WIDTH-1:0] number_in2,
  input  logic [WIDTH-1:0] number_in3,
  input  logic [WIDTH-1:0] number_in4,
  input  logic [WIDTH-1:0] number_in5,
  input  logic [WIDTH-1:0] number_in6,
  input  logic [WIDTH-1:0] number_in7,
  input  logic [WIDTH-1:0] number_in8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] number_out1,
  output logic [WIDTH-1:0] number_out2,
  output logic [WIDTH-1:0] number_out3,
  output logic [WIDTH-1:0] number_out4,
  output logic [WIDTH-1:0] number_out5,
  output logic [WIDTH-1:0] number_out6,
  output logic [WIDTH-1:0] number_out7,
  output logic [WIDTH-1:0] number_out8,
  output logic             busy
`ifdef BITONIC_S3_CHECK_EN
  ,
  output logic             bitonic_err
`endif
);

  state_e           state;
  logic [WIDTH-1:0] w      [LANES];
  logic [WIDTH-1:0] cas_a  [CAS_UNITS];
  logic [WIDTH-1:0] cas_b  [CAS_UNITS];
  logic [WIDTH-1:0] cas_lo [CAS_UNITS];
  logic [WIDTH-1:0] cas_hi [CAS_UNITS];

  // Route working lanes to the shared units according to the current layer.
  always_comb begin
    for (int k = 0; k < CAS_UNITS; k++) begin
      cas_a[k] = w[CMP4_A[k]];
      cas_b[k] = w[CMP4_B[k]];
      case (state)
        CMP2: begin
          cas_a[k] = w[CMP2_A[k]];
          cas_b[k] = w[CMP2_B[k]];
        end
        CMP1: begin
          cas_a[k] = w[CMP1_A[k]];
          cas_b[k] = w[CMP1_B[k]];
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < CAS_UNITS; g++) begin : g_cas
    bitonic_cas #(.WIDTH(WIDTH)) u_cas (
      .a  (cas_a[g]),
      .b  (cas_b[g]),
      .lo (cas_lo[g]),
      .hi (cas_hi[g])
    );
  end

`ifdef BITONIC_S3_CHECK_EN
  logic shape_bad;

  // Upper half must be non-increasing, lower half non-decreasing.
  always_comb begin
    shape_bad = !((number_in1 >= number_in2) && (number_in2 >= number_in3) &&
                  (number_in3 >= number_in4) && (number_in5 <= number_in6) &&
                  (number_in6 <= number_in7) && (number_in7 <= number_in8));
  end
`endif

  // FSM and working registers: load in IDLE, one layer per CMP state,
  // hold the result in DONE until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int i = 0; i < LANES; i++) w[i] <= '0;
`ifdef BITONIC_S3_CHECK_EN
      bitonic_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w[0]  <= number_in1;
            w[1]  <= number_in2;
            w[2]  <= number_in3;
            w[3]  <= number_in4;
            w[4]  <= number_in5;
            w[5]  <= number_in6;
            w[6]  <= number_in7;
            w[7]  <= number_in8;
            state <= CMP4;
`ifdef BITONIC_S3_CHECK_EN
            bitonic_err <= shape_bad;
`endif
          end
        end
        CMP4: begin
          for (int k = 0; k < CAS_UNITS; k++) begin
            w[CMP4_A[k]] <= cas_lo[k];
            w[CMP4_B[k]] <= cas_hi[k];
          end
          state <= CMP2;
        end
        CMP2: begin
          for (int k = 0; k < CAS_UNITS; k++) begin
            w[CMP2_A[k]] <= cas_lo[k];
            w[CMP2_B[k]] <= cas_hi[k];
          end
          state <= CMP1;
        end
        CMP1: begin
          for (int k = 0; k < CAS_UNITS; k++) begin
            w[CMP1_A[k]] <= cas_lo[k];
            w[CMP1_B[k]] <= cas_hi[k];
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decoded from the state register, forced low while in reset.
  always_comb begin
    in_ready  = rst_n && (state == IDLE);
    out_valid = rst_n && (state == DONE);
    busy      = rst_n && (state != IDLE);
  end

  // Result lanes come straight from the working registers.
  always_comb begin
    number_out1 = w[0];
    number_out2 = w[1];
    number_out3 = w[2];
    number_out4 = w[3];
    number_out5 = w[4];
    number_out6 = w[5];
    number_out7 = w[6];
    number_out8 = w[7];
  end

endmodule
